// File: rtl/srch_90k_enum.sv
// Enumerates every RE index of a 90 kHz search segment (or of the whole RE
// space) in ascending order over a valid/ready stream, tagging segment ends.
module srch_90k_enum #(
    parameter int RE_MAX = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_vld,
    output logic       req_rdy,
    input  logic [1:0] req_scs,
    input  logic [3:0] req_seg,
    input  logic       req_all,
    input  logic       abort,
    output logic       re_vld,
    input  logic       re_rdy,
    output logic [7:0] re_index,
    output logic [3:0] re_seg,
    output logic       re_seg_last,
    output logic       re_done,
    output logic       req_err
);
    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [7:0] RE_MAX8 = 8'(RE_MAX);
    localparam logic [8:0] RE_MAX9 = 9'(RE_MAX);

    state_t     state_q, state_d;
    logic [4:0] gap_q, gap_d;
    logic [7:0] idx_q, idx_d;
    logic [3:0] seg_q, seg_d;
    logic [4:0] cnt_q, cnt_d;
    logic [7:0] end_q, end_d;
    logic       err_q, err_d;

    logic [4:0] gap_req;
    logic [8:0] seg9, start9, end9;
    logic       accept, bad, beat;

    // Segment start via shift-add: 18=16+2, 6=4+2, 3=2+1.
    always_comb begin
        seg9    = {5'd0, req_seg};
        gap_req = 5'd0;
        start9  = 9'd0;
        case (req_scs)
            2'd1: begin gap_req = 5'd18; start9 = (seg9 << 4) + (seg9 << 1); end
            2'd2: begin gap_req = 5'd6;  start9 = (seg9 << 2) + (seg9 << 1); end
            2'd3: begin gap_req = 5'd3;  start9 = (seg9 << 1) + seg9;        end
            default: ;
        endcase
        end9 = start9 + {4'd0, gap_req} - 9'd1;
    end

    assign accept = req_vld && req_rdy && !abort;
    assign bad    = (req_scs == 2'd0) || (!req_all && (start9 > RE_MAX9));
    assign beat   = (state_q == RUN) && re_rdy && !abort;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            gap_q   <= 5'd0;
            idx_q   <= 8'd0;
            seg_q   <= 4'd0;
            cnt_q   <= 5'd0;
            end_q   <= 8'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            gap_q   <= gap_d;
            idx_q   <= idx_d;
            seg_q   <= seg_d;
            cnt_q   <= cnt_d;
            end_q   <= end_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept && !bad) state_d = RUN;
            RUN: begin
                if (abort)                 state_d = IDLE;
                else if (re_rdy && re_done) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        gap_d = gap_q;
        idx_d = idx_q;
        seg_d = seg_q;
        cnt_d = cnt_q;
        end_d = end_q;
        err_d = 1'b0;
        if (state_q == IDLE && accept) begin
            if (bad) begin
                err_d = 1'b1;
            end else begin
                gap_d = gap_req;
                cnt_d = 5'd0;
                if (req_all) begin
                    idx_d = 8'd0;
                    seg_d = 4'd0;
                    end_d = RE_MAX8;
                end else begin
                    idx_d = start9[7:0];
                    seg_d = req_seg;
                    end_d = (end9 > RE_MAX9) ? RE_MAX8 : end9[7:0];
                end
            end
        end else if (beat && !re_done) begin
            // Intra-segment counter replaces a divider for the segment tag.
            idx_d = idx_q + 8'd1;
            if (cnt_q == gap_q - 5'd1) begin
                cnt_d = 5'd0;
                seg_d = seg_q + 4'd1;
            end else begin
                cnt_d = cnt_q + 5'd1;
            end
        end
    end

    always_comb begin
        req_rdy     = (state_q == IDLE) && !rst;
        re_vld      = (state_q == RUN);
        re_index    = idx_q;
        re_seg      = seg_q;
        re_seg_last = re_vld && ((cnt_q == gap_q - 5'd1) || (idx_q == RE_MAX8));
        re_done     = re_vld && (idx_q == end_q);
        req_err     = err_q;
    end
endmodule

// File: tb/tb_srch_90k_enum.sv
// Directed bench for srch_90k_enum: vector table of requests plus
// hand-written backpressure, abort and async-reset sequences.
module tb_srch_90k_enum;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_vld = 1'b0, req_all = 1'b0, abort = 1'b0, re_rdy = 1'b1;
    logic [1:0] req_scs = 2'd0;
    logic [3:0] req_seg = 4'd0;
    logic       req_rdy, re_vld, re_seg_last, re_done, req_err;
    logic [7:0] re_index;
    logic [3:0] re_seg;

    int checks = 0;
    int failures = 0;

    typedef struct {
        int scs; int seg; int all;
        int lo;  int hi;  int err;
    } vec_t;

    srch_90k_enum #(.RE_MAX(255)) dut (
        .clk(clk), .rst(rst), .req_vld(req_vld), .req_rdy(req_rdy),
        .req_scs(req_scs), .req_seg(req_seg), .req_all(req_all), .abort(abort),
        .re_vld(re_vld), .re_rdy(re_rdy), .re_index(re_index), .re_seg(re_seg),
        .re_seg_last(re_seg_last), .re_done(re_done), .req_err(req_err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int gap_of(input int scs);
        return (scs == 1) ? 18 : (scs == 2) ? 6 : 3;
    endfunction

    // Checks one RE beat against a division-based reference.
    task automatic chk_beat(input int idx, input int gap, input int hi);
        chk("re_vld", int'(re_vld), 1);
        chk("re_index", int'(re_index), idx);
        chk("re_seg", int'(re_seg), (idx / gap) % 16);
        chk("re_seg_last", int'(re_seg_last),
            ((idx % gap) == gap - 1 || idx == 255) ? 1 : 0);
        chk("re_done", int'(re_done), (idx == hi) ? 1 : 0);
    endtask

    task automatic wait_rdy();
        int n = 0;
        while (!req_rdy && n < 20) begin step(); n++; end
        chk("req_rdy_wait", int'(req_rdy), 1);
    endtask

    task automatic issue(input int scs, input int seg, input int all);
        wait_rdy();
        req_scs = 2'(scs); req_seg = 4'(seg); req_all = all[0];
        req_vld = 1'b1;
        step();
        req_vld = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        issue(v.scs, v.seg, v.all);
        if (v.err != 0) begin
            chk("err_pulse", int'(req_err), 1);
            chk("err_no_vld", int'(re_vld), 0);
            step();
            chk("err_clear", int'(req_err), 0);
            chk("err_no_vld2", int'(re_vld), 0);
            chk("err_idle", int'(req_rdy), 1);
        end else begin
            re_rdy = 1'b1;
            chk("no_err", int'(req_err), 0);
            for (int i = v.lo; i <= v.hi; i++) begin
                chk_beat(i, gap_of(v.scs), v.hi);
                step();
            end
            chk("end_vld", int'(re_vld), 0);
            chk("end_rdy", int'(req_rdy), 1);
        end
    endtask

    vec_t vecs[$];

    initial begin
        vecs.push_back('{3, 2, 0, 6, 8, 0});
        vecs.push_back('{1, 14, 0, 252, 255, 0});
        vecs.push_back('{1, 15, 0, 0, 0, 1});
        vecs.push_back('{2, 0, 1, 0, 255, 0});
        vecs.push_back('{0, 3, 0, 0, 0, 1});
        vecs.push_back('{3, 15, 0, 45, 47, 0});
        vecs.push_back('{1, 7, 0, 126, 143, 0});

        #12;
        chk("rst_req_rdy", int'(req_rdy), 0);
        chk("rst_re_vld", int'(re_vld), 0);
        chk("rst_re_index", int'(re_index), 0);
        chk("rst_re_done", int'(re_done), 0);
        chk("rst_req_err", int'(req_err), 0);
        @(negedge clk);
        rst = 1'b0;
        step();
        chk("post_rst_rdy", int'(req_rdy), 1);

        for (int k = 0; k < vecs.size(); k++) run_vec(vecs[k]);

        // Backpressure: scs=2 seg=1 with a stuttering ready.
        begin
            bit pat[6] = '{1, 0, 0, 1, 0, 1};
            int idx = 6;
            int cyc = 0;
            issue(2, 1, 0);
            while (re_vld && cyc < 100) begin
                re_rdy = pat[cyc % 6];
                chk_beat(idx, 6, 11);
                step();
                if (re_rdy && idx <= 11) idx++;
                cyc++;
            end
            chk("bp_count", idx, 12);
            chk("bp_end_vld", int'(re_vld), 0);
            re_rdy = 1'b1;
        end

        // Abort together with acceptance cancels the request.
        wait_rdy();
        req_scs = 2'd1; req_seg = 4'd0; req_all = 1'b0;
        req_vld = 1'b1; abort = 1'b1;
        step();
        req_vld = 1'b0; abort = 1'b0;
        chk("acc_abort_vld", int'(re_vld), 0);
        chk("acc_abort_err", int'(req_err), 0);
        step();
        chk("acc_abort_vld2", int'(re_vld), 0);

        // Abort at re_index 5 with re_rdy high.
        issue(1, 0, 0);
        for (int i = 0; i < 5; i++) step();
        chk("abort_at5", int'(re_index), 5);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abort_vld", int'(re_vld), 0);
        chk("abort_done", int'(re_done), 0);
        chk("abort_idle", int'(req_rdy), 1);
        step();
        chk("abort_vld2", int'(re_vld), 0);

        // Async reset at re_index 9.
        issue(1, 0, 0);
        for (int i = 0; i < 9; i++) step();
        chk("rst_at9", int'(re_index), 9);
        rst = 1'b1;
        #1;
        chk("arst_vld", int'(re_vld), 0);
        chk("arst_index", int'(re_index), 0);
        chk("arst_seg", int'(re_seg), 0);
        chk("arst_rdy", int'(req_rdy), 0);
        chk("arst_last", int'(re_seg_last), 0);
        @(negedge clk);
        rst = 1'b0;
        step();
        chk("arst_recover", int'(req_rdy), 1);
        run_vec(vecs[0]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
